word_width_reducer: RTL and testbench
=====================================

Name: word_width_reducer

Overview:
- Registered serializer: accepts one wide word over a ready/valid handshake and emits it as WORD_COUNT narrow words over a second ready/valid handshake.
- Used where a wide datapath must feed a narrower one without dropping bits. It is the lossless, sequential counterpart to the combinational width truncation/extension used elsewhere in the datapath.
- Zero-bubble when the downstream side never stalls.

Parameters:
- WORD_WIDTH_OUT, 8, width of each emitted narrow word (>=1).
- WORD_COUNT, 4, number of narrow words per input word (>=1).
- MSB_FIRST, 0, 0 = least-significant slice emitted first; 1 = most-significant slice first.
- Derived (localparam, not overridable): WORD_WIDTH_IN = WORD_WIDTH_OUT * WORD_COUNT.

Ports:
- clock  input  1  sole clock; all state updates on its rising edge.
- clear  input  1  synchronous, active-high reset.
- input_valid  input  1  input_data is offered.
- input_ready  output  1  block can accept input_data this cycle.
- input_data  input  WORD_WIDTH_IN  wide word to serialize.
- output_valid  output  1  output_data holds a valid narrow word.
- output_ready  input  1  downstream accepts output_data this cycle.
- output_data  output  WORD_WIDTH_OUT  current narrow slice.
- output_last  output  1  current slice is the final slice of its wide word.

Behaviour:
- Clock and reset: one clock, clock. Reset is clear, synchronous and active-high.
- State: holding register (WORD_WIDTH_IN), slice counter (0..WORD_COUNT-1), state in {EMPTY, SENDING}.
- Reset (clear=1 at an edge):
  - state=EMPTY, counter=0, holding register=0.
  - Outputs after the edge: output_valid=0, output_data=0, output_last=0, input_ready=1.
  - clear overrides any handshake in the same cycle. A partially sent word is discarded, and no input is captured.
- input_ready = (state==EMPTY) OR (state==SENDING AND output_last AND output_ready). It is combinational from state and output_ready, with no path from input_valid.
- Input handshake (input_valid AND input_ready at an edge):
  - load holding register with input_data, counter=0, state=SENDING.
  - The first slice is valid in the cycle after acceptance (latency 1).
- output_valid = (state==SENDING).
- output_data:
  - MSB_FIRST=0: holding register bits [WORD_WIDTH_OUT-1:0].
  - MSB_FIRST=1: bits [WORD_WIDTH_IN-1:WORD_WIDTH_IN-WORD_WIDTH_OUT].
  - Driven directly from the register; no combinational path from inputs.
- output_last = output_valid AND (counter==WORD_COUNT-1).
- Output handshake (output_valid AND output_ready):
  - Non-last slice: shift the holding register by WORD_WIDTH_OUT toward the emitted end, fill with zeros, counter+1.
  - Last slice with a simultaneous input handshake: load the new word, counter=0, stay SENDING. This is the back-to-back case with no bubble.
  - Last slice with no input: state=EMPTY, counter=0.
- Backpressure: while output_valid=1 and output_ready=0, output_data, output_last and the counter hold stable. output_valid never drops without a handshake or clear.
- Throughput: one wide word per WORD_COUNT cycles at full rate.
- WORD_COUNT=1: behaves as a one-deep registered pipeline stage; output_last is always equal to output_valid.
- Counter wrap: the counter never exceeds WORD_COUNT-1. Its width is clog2(WORD_COUNT), minimum 1.
- No arithmetic on data. Bits are reordered only, never sign-extended or truncated.

Test Plan:
- Defaults; offer 0xDDCCBBAA with output_ready=1 -> accepted at cycle t. Output is 0xAA,0xBB,0xCC,0xDD at t+1..t+4, output_last=1 only with 0xDD, then output_valid=0 at t+5.
- MSB_FIRST=1; offer 0xDDCCBBAA -> output 0xDD,0xCC,0xBB,0xAA, output_last with 0xAA.
- Two words 0x44332211 and 0x88776655 held valid, output_ready=1 -> 8 consecutive valid cycles 0x11..0x88 with no gap. input_ready=1 only in the cycle of each last slice (and when EMPTY).
- Backpressure: output_ready=0 for 3 cycles while 0xBB is presented -> 0xBB, output_valid=1 and output_last=0 held all 3 cycles. No slice is lost or duplicated after release.
- input_valid=1 with 0x55555555 while a non-last slice is pending -> input_ready=0 and the word is not captured until the last slice handshake.
- clear=1 for one cycle after 0xAA,0xBB have been sent -> next cycle output_valid=0, output_data=0, input_ready=1. New word 0x44332211 then emits starting at 0x11 with a counter of 0.

Source files
------------

// File: rtl/word_width_reducer.sv
// word_width_reducer: serializes one wide word into WORD_COUNT narrow words over ready/valid
module word_width_reducer #(
    parameter int WORD_WIDTH_OUT = 8,
    parameter int WORD_COUNT     = 4,
    parameter bit MSB_FIRST      = 1'b0
) (
    input  logic                                 clock,
    input  logic                                 clear,
    input  logic                                 input_valid,
    output logic                                 input_ready,
    input  logic [WORD_WIDTH_OUT*WORD_COUNT-1:0] input_data,
    output logic                                 output_valid,
    input  logic                                 output_ready,
    output logic [WORD_WIDTH_OUT-1:0]            output_data,
    output logic                                 output_last
);
    localparam int WORD_WIDTH_IN = WORD_WIDTH_OUT * WORD_COUNT;
    localparam int CW = WORD_COUNT > 1 ? $clog2(WORD_COUNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORD_COUNT - 1);
    typedef enum logic {EMPTY, SENDING} state_t;
    state_t                   state;
    logic [CW-1:0]            count;
    logic [WORD_WIDTH_IN-1:0] hold;
    logic                     in_fire;
    logic                     out_fire;
    assign output_valid = state == SENDING;
    assign output_last  = output_valid && count == LAST;
    assign input_ready  = state == EMPTY || (output_last && output_ready);
    assign in_fire      = input_valid && input_ready;
    assign out_fire     = output_valid && output_ready;
    assign output_data  = MSB_FIRST ? hold[WORD_WIDTH_IN-1 -: WORD_WIDTH_OUT] : hold[WORD_WIDTH_OUT-1:0];
    // Load on input handshake, otherwise shift the emitted slice out and advance/retire on output handshake
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= EMPTY;
            count <= '0;
            hold  <= '0;
        end else if (in_fire) begin
            state <= SENDING;
            count <= '0;
            hold  <= input_data;
        end else if (out_fire) begin
            state <= output_last ? EMPTY : SENDING;
            count <= output_last ? '0 : count + 1'b1;
            hold  <= MSB_FIRST ? hold << WORD_WIDTH_OUT : hold >> WORD_WIDTH_OUT;
        end
    end
endmodule

// File: tb/tb_word_width_reducer.sv
// tb_word_width_reducer: scoreboard bench driving an LSB-first and an MSB-first instance in lockstep
module tb_word_width_reducer;
    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        input_valid = 1'b0;
    logic [31:0] input_data = '0;
    logic        output_ready = 1'b0;
    logic        input_ready, output_valid, output_last;
    logic [7:0]  output_data;
    logic        m_input_ready, m_output_valid, m_output_last;
    logic [7:0]  m_output_data;
    logic [8:0]  q0[$];
    logic [8:0]  q1[$];
    int          vectors = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    word_width_reducer dut (
        .clock(clock), .clear(clear), .input_valid(input_valid), .input_ready(input_ready),
        .input_data(input_data), .output_valid(output_valid), .output_ready(output_ready),
        .output_data(output_data), .output_last(output_last)
    );

    word_width_reducer #(.WORD_WIDTH_OUT(8), .WORD_COUNT(4), .MSB_FIRST(1'b1)) dut_m (
        .clock(clock), .clear(clear), .input_valid(input_valid), .input_ready(m_input_ready),
        .input_data(input_data), .output_valid(m_output_valid), .output_ready(output_ready),
        .output_data(m_output_data), .output_last(m_output_last)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // LSB-first monitor: every output handshake must match the head of its queue
    always @(negedge clock) begin
        if (!clear && output_valid && output_ready) begin
            if (q0.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL lsb_unexpected: got 0x%0h with nothing expected at %0t", {output_last, output_data}, $time);
            end else
                chk("lsb_slice", 32'({output_last, output_data}), 32'(q0.pop_front()));
        end
    end

    // MSB-first monitor
    always @(negedge clock) begin
        if (!clear && m_output_valid && output_ready) begin
            if (q1.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL msb_unexpected: got 0x%0h with nothing expected at %0t", {m_output_last, m_output_data}, $time);
            end else
                chk("msb_slice", 32'({m_output_last, m_output_data}), 32'(q1.pop_front()));
        end
    end

    task automatic push(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            q0.push_back({i == 3, w[8*i +: 8]});
            q1.push_back({i == 3, w[8*(3-i) +: 8]});
        end
    endtask

    task automatic send(input logic [31:0] w);
        logic rdy;
        bit   ok;
        ok = 1'b0;
        push(w);
        input_valid = 1'b1;
        input_data  = w;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clock);
            rdy = input_ready;
            @(posedge clock);
            #1;
            ok = rdy;
        end
        input_valid = 1'b0;
        if (!ok) chk("send_timeout", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && (q0.size() != 0 || q1.size() != 0); n++) @(posedge clock);
        chk("drain_lsb_empty", 32'(q0.size()), 32'd0);
        chk("drain_msb_empty", 32'(q1.size()), 32'd0);
        @(negedge clock);
        chk("idle_valid", 32'({output_valid, m_output_valid}), 32'd0);
        chk("idle_ready", 32'({input_ready, m_input_ready}), 32'd3);
        @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b0;
        @(negedge clock);
        chk("reset_valid", 32'({output_valid, m_output_valid}), 32'd0);
        chk("reset_data", 32'({output_data, m_output_data}), 32'd0);
        chk("reset_last", 32'({output_last, m_output_last}), 32'd0);
        chk("reset_ready", 32'({input_ready, m_input_ready}), 32'd3);
        @(posedge clock);
        #1;

        // single word, full rate, both slice orders
        output_ready = 1'b1;
        send(32'hDDCCBBAA);
        drain();

        // back-to-back words: no bubble, input_ready only on last slices
        push(32'h44332211);
        push(32'h88776655);
        input_valid = 1'b1;
        input_data  = 32'h44332211;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            chk("b2b_valid", 32'(output_valid), 32'(c >= 1 && c <= 8));
            chk("b2b_ready", 32'(input_ready), 32'(c == 0 || c == 4 || c == 8 || c == 9));
            @(posedge clock);
            #1;
            if (c == 0) input_data = 32'h88776655;
            if (c == 4) input_valid = 1'b0;
        end
        drain();

        // backpressure while 0xBB is presented
        output_ready = 1'b0;
        send(32'hDDCCBBAA);
        output_ready = 1'b1;
        @(posedge clock);
        #1;
        output_ready = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("bp_data", 32'(output_data), 32'hBB);
            chk("bp_valid", 32'(output_valid), 32'd1);
            chk("bp_last", 32'(output_last), 32'd0);
            chk("bp_msb_data", 32'(m_output_data), 32'hCC);
            @(posedge clock);
            #1;
        end
        output_ready = 1'b1;
        drain();

        // new word offered while a non-last slice is pending
        output_ready = 1'b0;
        send(32'hDDCCBBAA);
        input_valid = 1'b1;
        input_data  = 32'h55555555;
        repeat (2) begin
            @(negedge clock);
            chk("busy_ready", 32'(input_ready), 32'd0);
            @(posedge clock);
            #1;
        end
        output_ready = 1'b1;
        send(32'h55555555);
        drain();

        // clear mid-word discards the remainder
        send(32'hDDCCBBAA);
        @(negedge clock);
        @(posedge clock);
        #1;
        @(negedge clock);
        @(posedge clock);
        #1;
        clear = 1'b1;
        output_ready = 1'b0;
        @(posedge clock);
        #1;
        clear = 1'b0;
        q0.delete();
        q1.delete();
        @(negedge clock);
        chk("clr_valid", 32'({output_valid, m_output_valid}), 32'd0);
        chk("clr_data", 32'({output_data, m_output_data}), 32'd0);
        chk("clr_ready", 32'({input_ready, m_input_ready}), 32'd3);
        @(posedge clock);
        #1;
        output_ready = 1'b1;
        send(32'h44332211);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
